cpu_plic_master: RTL and testbench

CPU_PLIC_MASTER -- requirements
Module: cpu_plic_master

---
 rtl/cpu_plic_master.sv | 196 +++++++++++++++++++
 tb/tb_cpu_plic_master.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cpu_plic_master.sv
// CPU-side PLIC master: programs the source-enable register, claims
// interrupt IDs over a simple request/ready bus, hands them to the trap
// logic and writes the completion back once the handler is done.
module cpu_plic_master #(
  parameter logic [23:0] ADDR_ENABLE = 24'h002000,
  parameter logic [23:0] ADDR_CLAIM  = 24'h200004,
  parameter int          TIMEOUT     = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_interrupt,
  input  logic [3:0]  i_enable_mask,
  input  logic        i_mask_update,
  output logic        o_request,
  output logic        o_rw,
  output logic [23:0] o_address,
  output logic [31:0] o_wdata,
  input  logic [31:0] i_rdata,
  input  logic        i_ready,
  output logic        o_irq_valid,
  output logic [2:0]  o_irq_id,
  input  logic        i_irq_taken,
  input  logic        i_complete,
  output logic        o_busy,
  output logic [7:0]  o_spurious,
  output logic        o_bus_error
);

  localparam logic [2:0] S_INIT      = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_CLAIM     = 3'd2;
  localparam logic [2:0] S_DELIVER   = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_COMPLETE  = 3'd5;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [2:0]    state_q, state_d;
  logic          req_q, req_d;
  logic          rw_q, rw_d;
  logic [23:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    id_q, id_d;
  logic [7:0]    spur_q, spur_d;
  logic          berr_q, berr_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout;
  logic          claim_ok;

  // Bus timer: the last waiting cycle of a TIMEOUT-long request aborts it.
  assign timeout  = req_q && !i_ready && (cnt_q == CW'(TIMEOUT - 1));
  assign claim_ok = (i_rdata != 32'd0) && (i_rdata <= 32'd4);

  // Next-state, bus-driver and bookkeeping logic.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    id_d    = id_q;
    spur_d  = spur_q;
    berr_d  = berr_q;
    pend_d  = pend_q;
    cnt_d   = (req_q && !i_ready && !timeout) ? cnt_q + 1'b1 : '0;

    // A mask change while busy is held until the next IDLE visit.
    if (i_mask_update && state_q != S_IDLE) pend_d = 1'b1;

    case (state_q)
      S_INIT: begin
        if (!req_q) begin
          req_d   = 1'b1;
          rw_d    = 1'b1;
          addr_d  = ADDR_ENABLE;
          wdata_d = {27'b0, i_enable_mask, 1'b0};
        end else if (i_ready) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else if (timeout) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (i_mask_update || pend_q) begin
          pend_d  = 1'b0;
          state_d = S_INIT;
          req_d   = 1'b1;
          rw_d    = 1'b1;
          addr_d  = ADDR_ENABLE;
          wdata_d = {27'b0, i_enable_mask, 1'b0};
        end else if (i_interrupt) begin
          state_d = S_CLAIM;
          req_d   = 1'b1;
          rw_d    = 1'b0;
          addr_d  = ADDR_CLAIM;
          wdata_d = '0;
        end
      end
      S_CLAIM: begin
        if (!req_q) begin
          req_d   = 1'b1;
          rw_d    = 1'b0;
          addr_d  = ADDR_CLAIM;
          wdata_d = '0;
        end else if (i_ready) begin
          req_d = 1'b0;
          if (claim_ok) begin
            id_d    = i_rdata[2:0];
            state_d = S_DELIVER;
          end else begin
            if (spur_q != 8'hFF) spur_d = spur_q + 8'd1;
            state_d = S_IDLE;
          end
        end else if (timeout) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DELIVER: begin
        if (i_irq_taken) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_complete) begin
          state_d = S_COMPLETE;
          req_d   = 1'b1;
          rw_d    = 1'b1;
          addr_d  = ADDR_CLAIM;
          wdata_d = {29'b0, id_q};
        end
      end
      S_COMPLETE: begin
        if (!req_q) begin
          req_d   = 1'b1;
          rw_d    = 1'b1;
          addr_d  = ADDR_CLAIM;
          wdata_d = {29'b0, id_q};
        end else if (i_ready) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else if (timeout) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          id_d    = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_INIT;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_INIT;
      req_q   <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      id_q    <= '0;
      spur_q  <= '0;
      berr_q  <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      id_q    <= id_d;
      spur_q  <= spur_d;
      berr_q  <= berr_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_request   = req_q;
  assign o_rw        = rw_q;
  assign o_address   = addr_q;
  assign o_wdata     = wdata_q;
  assign o_irq_valid = (state_q == S_DELIVER);
  assign o_irq_id    = id_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_spurious  = spur_q;
  assign o_bus_error = berr_q;

endmodule

// File: tb/tb_cpu_plic_master.sv
// Directed bench for cpu_plic_master: enable programming, claim/complete,
// spurious claims, no-nesting, deferred mask update, timeout and reset.
module tb_cpu_plic_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        intr;
  logic [3:0]  mask;
  logic        mupd;
  logic        req, rw;
  logic [23:0] addr;
  logic [31:0] wdata, rdata;
  logic        rdy;
  logic        irq_valid;
  logic [2:0]  irq_id;
  logic        taken, complete;
  logic        busy;
  logic [7:0]  spur;
  logic        berr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_plic_master dut (
    .i_clock(clk), .i_reset(rst), .i_interrupt(intr),
    .i_enable_mask(mask), .i_mask_update(mupd),
    .o_request(req), .o_rw(rw), .o_address(addr), .o_wdata(wdata),
    .i_rdata(rdata), .i_ready(rdy),
    .o_irq_valid(irq_valid), .o_irq_id(irq_id),
    .i_irq_taken(taken), .i_complete(complete),
    .o_busy(busy), .o_spurious(spur), .o_bus_error(berr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, check it, answer with one ready cycle.
  task automatic bus_xfer(input string tag, input logic erw, input logic [23:0] eaddr,
                          input logic [31:0] ewdata, input logic [31:0] rd);
    int n = 0;
    while (!req && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_req"}, {31'b0, req}, 32'd1);
    chk({tag, "_rw"}, {31'b0, rw}, {31'b0, erw});
    chk({tag, "_addr"}, {8'b0, addr}, {8'b0, eaddr});
    if (erw) chk({tag, "_wdata"}, wdata, ewdata);
    rdy = 1'b1; rdata = rd;
    @(negedge clk);
    rdy = 1'b0; rdata = '0;
    chk({tag, "_drop"}, {31'b0, req}, 32'd0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int hi;
    int seen;
    rst = 1'b1; intr = 1'b0; mask = 4'b0101; mupd = 1'b0;
    rdata = '0; rdy = 1'b0; taken = 1'b0; complete = 1'b0;
    cycles(3);
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_addr", {8'b0, addr}, 32'd0);
    chk("rst_spur", {24'b0, spur}, 32'd0);
    chk("rst_berr", {31'b0, berr}, 32'd0);
    chk("rst_valid", {31'b0, irq_valid}, 32'd0);

    // Enable write after reset release.
    rst = 1'b0;
    bus_xfer("init", 1'b1, 24'h002000, 32'h0000000A, 32'h0);
    chk("init_idle", {31'b0, busy}, 32'd0);

    // Normal claim of ID 2.
    intr = 1'b1;
    @(negedge clk);
    chk("claim_req_next", {31'b0, req}, 32'd1);
    bus_xfer("claim2", 1'b0, 24'h200004, 32'h0, 32'd2);
    intr = 1'b0;
    chk("deliver_valid", {31'b0, irq_valid}, 32'd1);
    chk("deliver_id", {29'b0, irq_id}, 32'd2);
    complete = 1'b1; @(negedge clk); complete = 1'b0;   // ignored outside WAIT_DONE
    chk("early_complete", {31'b0, irq_valid}, 32'd1);
    taken = 1'b1; @(negedge clk); taken = 1'b0;
    chk("taken_valid", {31'b0, irq_valid}, 32'd0);
    chk("taken_busy", {31'b0, busy}, 32'd1);
    complete = 1'b1; @(negedge clk); complete = 1'b0;
    bus_xfer("cmpl2", 1'b1, 24'h200004, 32'h2, 32'h0);
    chk("cmpl2_idle", {31'b0, busy}, 32'd0);

    // Spurious claim (ID 0).
    intr = 1'b1;
    @(negedge clk);
    intr = 1'b0;
    bus_xfer("spur0", 1'b0, 24'h200004, 32'h0, 32'd0);
    chk("spur0_cnt", {24'b0, spur}, 32'd1);
    chk("spur0_valid", {31'b0, irq_valid}, 32'd0);
    chk("spur0_idle", {31'b0, busy}, 32'd0);

    // No nesting in WAIT_DONE; mask update there is deferred.
    intr = 1'b1;
    bus_xfer("claim3", 1'b0, 24'h200004, 32'h0, 32'd3);
    taken = 1'b1; @(negedge clk); taken = 1'b0;
    mask = 4'b1100; mupd = 1'b1; @(negedge clk); mupd = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      intr = (i % 3) != 0;
      @(negedge clk);
      if (req) seen++;
    end
    chk("nonest_req", seen, 0);
    intr = 1'b1;
    complete = 1'b1; @(negedge clk); complete = 1'b0;
    bus_xfer("cmpl3", 1'b1, 24'h200004, 32'h3, 32'h0);
    bus_xfer("reinit", 1'b1, 24'h002000, 32'h00000018, 32'h0);
    bus_xfer("claim5", 1'b0, 24'h200004, 32'h0, 32'd5);
    intr = 1'b0;
    chk("spur5_cnt", {24'b0, spur}, 32'd2);

    // Timeout: responder never answers the claim.
    intr = 1'b1;
    hi = 0;
    for (int i = 0; i < 20 && !req; i++) @(negedge clk);
    intr = 1'b0;
    for (int i = 0; i < 400 && req; i++) begin hi++; @(negedge clk); end
    chk("to_len", hi, 255);
    chk("to_berr", {31'b0, berr}, 32'd1);
    chk("to_idle", {31'b0, busy}, 32'd0);
    cycles(3);
    chk("berr_sticky", {31'b0, berr}, 32'd1);

    // Reset in the middle of a claim.
    intr = 1'b1;
    for (int i = 0; i < 20 && !req; i++) @(negedge clk);
    chk("mid_req", {31'b0, req}, 32'd1);
    rst = 1'b1; intr = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", {31'b0, req}, 32'd0);
    chk("mid_rst_berr", {31'b0, berr}, 32'd0);
    chk("mid_rst_spur", {24'b0, spur}, 32'd0);
    chk("mid_rst_id", {29'b0, irq_id}, 32'd0);
    rst = 1'b0;
    bus_xfer("postrst", 1'b1, 24'h002000, 32'h00000018, 32'h0);
    chk("postrst_idle", {31'b0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
